alu_cmd_ctrl: RTL and testbench

Sequencing front-end for the 8-bit combinational `alu`. It accepts ALU commands (operands plus 3-bit opcode) over a valid/ready handshake and buffers them in a small FIFO. It drives the `alu` inputs from registered operands, captures the `alu` result, carry and a derived zero flag into a response register, and presents them downstream over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu command front-end: opcodes, FSM state encodings
// and the default operand width.
package alu_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty
// stay distinguishable when the index bits match.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    // A full FIFO refuses a push even when the same cycle pops.
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Sequencing front-end for the combinational alu: buffers commands, drives registered
// operands, captures result/carry/zero. Define ALU_CTRL_ACC_EN for the accumulator operand.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    input  logic [2:0]        i_cmd_op,
    input  logic              i_cmd_acc,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [2:0]        o_alu_op,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic              i_alu_carry,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_res,
    output logic              o_rsp_carry,
    output logic              o_rsp_zero
);

`ifdef ALU_CTRL_ACC_EN
    localparam int ENTRY_W = 2 * DATA_W + 4;
`else
    localparam int ENTRY_W = 2 * DATA_W + 3;
`endif

    state_e              state_r;
    state_e              state_next_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_wdata_s;
    logic [ENTRY_W-1:0]  fifo_rdata_s;
    logic [DATA_W-1:0]   head_a_s;
    logic [DATA_W-1:0]   head_b_s;
    logic [2:0]          head_op_s;
    logic [DATA_W-1:0]   load_a_s;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [2:0]          alu_op_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_res_r;
    logic                rsp_carry_r;
    logic                rsp_zero_r;

    assign head_a_s  = fifo_rdata_s[DATA_W-1:0];
    assign head_b_s  = fifo_rdata_s[2*DATA_W-1:DATA_W];
    assign head_op_s = fifo_rdata_s[2*DATA_W+2:2*DATA_W];

`ifdef ALU_CTRL_ACC_EN
    logic [DATA_W-1:0] acc_r;

    assign fifo_wdata_s = {i_cmd_acc, i_cmd_op, i_cmd_b, i_cmd_a};
    assign load_a_s     = fifo_rdata_s[ENTRY_W-1] ? acc_r : head_a_s;

    // Accumulator follows every captured result.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_EXEC) begin
            acc_r <= i_alu_res;
        end
    end
`else
    logic acc_unused_s;

    assign acc_unused_s = i_cmd_acc;
    assign fifo_wdata_s = {i_cmd_op, i_cmd_b, i_cmd_a};
    assign load_a_s     = head_a_s;
`endif

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (i_cmd_valid),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and pop decode.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_EXEC;
                end else if (i_rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand registers reload only on a pop, so they hold through RESP.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            alu_a_r  <= {DATA_W{1'b0}};
            alu_b_r  <= {DATA_W{1'b0}};
            alu_op_r <= 3'd0;
        end else if (pop_s) begin
            alu_a_r  <= load_a_s;
            alu_b_r  <= head_b_s;
            alu_op_r <= head_op_s;
        end
    end

    // Response capture at the end of EXEC; valid drops on the accepting edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rsp_valid_r <= 1'b0;
            rsp_res_r   <= {DATA_W{1'b0}};
            rsp_carry_r <= 1'b0;
            rsp_zero_r  <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_res_r   <= i_alu_res;
            rsp_carry_r <= i_alu_carry;
            rsp_zero_r  <= (i_alu_res == {DATA_W{1'b0}});
        end else if ((state_r == ST_RESP) && i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign o_cmd_ready = !fifo_full_s;
    assign o_alu_a     = alu_a_r;
    assign o_alu_b     = alu_b_r;
    assign o_alu_op    = alu_op_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_res   = rsp_res_r;
    assign o_rsp_carry = rsp_carry_r;
    assign o_rsp_zero  = rsp_zero_r;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural alu beside the DUT.
// Expectations also follow ALU_CTRL_ACC_EN when it is defined.
module tb_alu_cmd_ctrl;

`ifdef ALU_CTRL_ACC_EN
    localparam bit ACC_ON = 1'b1;
    localparam logic [9:0] ACC_SECOND = 10'h011;
`else
    localparam bit ACC_ON = 1'b0;
    localparam logic [9:0] ACC_SECOND = 10'h051;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } rsp_t;

    logic       i_clk;
    logic       i_rstn;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_a;
    logic [7:0] i_cmd_b;
    logic [2:0] i_cmd_op;
    logic       i_cmd_acc;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [2:0] o_alu_op;
    logic [7:0] i_alu_res;
    logic       i_alu_carry;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_res;
    logic       o_rsp_carry;
    logic       o_rsp_zero;

    rsp_t       exp_q[$];
    logic [9:0] got_q[$];
    int         hs_times[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] model_acc = 8'h00;
    bit         rand_ready = 1'b0;

    alu_cmd_ctrl #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_a     (i_cmd_a),
        .i_cmd_b     (i_cmd_b),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_acc   (i_cmd_acc),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .i_alu_res   (i_alu_res),
        .i_alu_carry (i_alu_carry),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_res   (o_rsp_res),
        .o_rsp_carry (o_rsp_carry),
        .o_rsp_zero  (o_rsp_zero)
    );

    // Opcode semantics of the alu; bit 8 is carry (borrow for SUB).
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {1'b0, a >> b[2:0]};
            default: r = {1'b0, a << b[2:0]};
        endcase
        return r;
    endfunction

    assign {i_alu_carry, i_alu_res} = alu_f(o_alu_a, o_alu_b, o_alu_op);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Cycle counter for throughput measurement.
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: commands complete in order and each result becomes the accumulator.
    task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic acc);
        logic [7:0] ea;
        logic [8:0] r;
        rsp_t       e;
        ea = (ACC_ON && acc) ? model_acc : a;
        r  = alu_f(ea, b, op);
        model_acc = r[7:0];
        e.res   = r[7:0];
        e.carry = r[8];
        e.zero  = (r[7:0] == 8'h00);
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic acc);
        bit done = 1'b0;
        @(negedge i_clk);
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_op    = op;
        i_cmd_acc   = acc;
        i_cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (o_cmd_ready) begin
                model_push(a, b, op, acc);
                @(posedge i_clk);
                done = 1'b1;
            end else begin
                @(negedge i_clk);
            end
        end
        #1;
        i_cmd_valid = 1'b0;
        check("push_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
            @(negedge i_clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge i_clk);
    endtask

    function automatic logic [9:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 10'h3FF;
    endfunction

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rstn && o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got res 0x%0h with no command outstanding", o_rsp_res);
                end else begin
                    e = exp_q[0];
                    check("rsp_res", {24'd0, o_rsp_res}, {24'd0, e.res});
                    check("rsp_carry", {31'd0, o_rsp_carry}, {31'd0, e.carry});
                    check("rsp_zero", {31'd0, o_rsp_zero}, {31'd0, e.zero});
                    if (i_rsp_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back({o_rsp_carry, o_rsp_zero, o_rsp_res});
                        hs_times.push_back(cyc);
                    end
                end
            end
        end
    end

    // Random downstream backpressure during the random phase.
    initial begin
        forever begin
            @(negedge i_clk);
            if (rand_ready) i_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int lat;
        logic [9:0] bp_exp [5];
        bp_exp[0] = 10'h0FF; bp_exp[1] = 10'h100; bp_exp[2] = 10'h0FF;
        bp_exp[3] = 10'h0F0; bp_exp[4] = 10'h003;

        i_rstn = 1'b0; i_cmd_valid = 1'b0; i_rsp_ready = 1'b0;
        i_cmd_a = 8'h00; i_cmd_b = 8'h00; i_cmd_op = 3'd0; i_cmd_acc = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("reset_alu_a", {24'd0, o_alu_a}, 32'd0);
        check("reset_rsp_res", {24'd0, o_rsp_res}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // ADD and response latency.
        i_rsp_ready = 1'b1;
        got_q.delete();
        push_cmd(8'h0F, 8'h01, 3'd0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge i_clk);
            #1;
            if (o_rsp_valid) lat = k;
        end
        check("add_latency_edges", lat, 32'd2);
        wait_drain();
        check("add_result", {22'd0, got_at(0)}, 32'h010);

        // ADD overflow.
        got_q.delete();
        push_cmd(8'hFF, 8'h01, 3'd0, 1'b0);
        wait_drain();
        check("add_overflow", {22'd0, got_at(0)}, 32'h300);

        // Backpressure: five commands fill EXEC/RESP plus the FIFO.
        got_q.delete();
        i_rsp_ready = 1'b0;
        push_cmd(8'h0F, 8'hF0, 3'd4, 1'b0);
        push_cmd(8'h0F, 8'hF0, 3'd2, 1'b0);
        push_cmd(8'h0F, 8'hF0, 3'd3, 1'b0);
        push_cmd(8'h0F, 8'h00, 3'd5, 1'b0);
        push_cmd(8'h0F, 8'h02, 3'd6, 1'b0);
        repeat (2) @(negedge i_clk);
        #1;
        check("full_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
        repeat (6) @(negedge i_clk);
        check("held_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        i_rsp_ready = 1'b1;
        wait_drain();
        check("bp_count", got_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) check("bp_order", {22'd0, got_at(i)}, {22'd0, bp_exp[i]});

        // Back-to-back, every opcode.
        got_q.delete();
        hs_times.delete();
        for (int op = 0; op < 8; op++) begin
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(op), 1'b0);
        end
        wait_drain();
        check("b2b_count", got_q.size(), 32'd8);
        for (int i = 1; i < 8 && i < hs_times.size(); i++) begin
            check("b2b_gap", hs_times[i] - hs_times[i-1], 32'd2);
        end

        // Reset while a response is held and three commands are queued.
        i_rsp_ready = 1'b0;
        push_cmd(8'h33, 8'h44, 3'd0, 1'b0);
        push_cmd(8'h35, 8'h46, 3'd3, 1'b0);
        push_cmd(8'h37, 8'h48, 3'd4, 1'b0);
        push_cmd(8'h39, 8'h4A, 3'd0, 1'b0);
        for (int k = 0; k < 20 && !o_rsp_valid; k++) @(negedge i_clk);
        check("pre_reset_valid", {31'd0, o_rsp_valid}, 32'd1);
        @(posedge i_clk);
        #3;
        i_rstn = 1'b0;
        exp_q.delete();
        model_acc = 8'h00;
        #1;
        check("mid_reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("mid_reset_rsp_res", {24'd0, o_rsp_res}, 32'd0);
        check("mid_reset_flags", {30'd0, o_rsp_carry, o_rsp_zero}, 32'd0);
        check("mid_reset_alu", {13'd0, o_alu_op, o_alu_b, o_alu_a}, 32'd0);
        check("mid_reset_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        i_rsp_ready = 1'b1;
        repeat (10) @(negedge i_clk);
        #1;
        check("post_reset_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("post_reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);

        // Accumulator operand (stored A used when the feature is absent).
        got_q.delete();
        push_cmd(8'h0F, 8'h01, 3'd0, 1'b0);
        push_cmd(8'h50, 8'h01, 3'd0, 1'b1);
        wait_drain();
        check("acc_first", {22'd0, got_at(0)}, 32'h010);
        check("acc_second", {22'd0, got_at(1)}, {22'd0, ACC_SECOND});

        // Random commands under random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
